// File: rtl/lock_display_scanner.sv
// rtl/lock_display_scanner.sv - six-digit multiplexed seven-segment scanner
// Double-buffered digits with frame-aligned transfer, per-digit dash masking and blink.
module lock_display_scanner #(
  parameter int REFRESH_DIV    = 4,
  parameter int BLINK_FRAMES   = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic [5:0] mask,
  input  logic       blink_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done,
  output logic       pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic POL = SEG_ACTIVE_LOW;

  logic [PW-1:0]     presc_q;
  logic [2:0]        slot_q;
  logic [BW-1:0]     blink_cnt_q;
  logic              phase_q;
  logic [5:0][3:0]   stage_q;
  logic [5:0][3:0]   active_q;
  logic [5:0]        stage_mask_q;
  logic [5:0]        active_mask_q;
  logic              pending_q;
  logic              frame_done_q;
  logic [5:0]        an_q;
  logic [6:0]        seg_q;

  logic [5:0][3:0]   din;
  logic              tick;
  logic              boundary;
  logic              pending_d;
  logic [5:0]        an_d;
  logic [6:0]        seg_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b0111111;
      4'h1:    decode = 7'b0000110;
      4'h2:    decode = 7'b1011011;
      4'h3:    decode = 7'b1001111;
      4'h4:    decode = 7'b1100110;
      4'h5:    decode = 7'b1101101;
      4'h6:    decode = 7'b1111101;
      4'h7:    decode = 7'b0000111;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1101111;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b1111100;
      4'hC:    decode = 7'b0111001;
      4'hD:    decode = 7'b1011110;
      4'hE:    decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    din       = {d6, d5, d4, d3, d2, d1};
    tick      = (presc_q == PRESC_LAST);
    boundary  = tick && (slot_q == 3'd5);
    pending_d = boundary ? 1'b0 : (load | pending_q);
    // Blanking looks at blink_en directly so dropping it relights on the next cycle.
    an_d      = ((phase_q && blink_en) ? 6'b000000 : (6'b000001 << slot_q)) ^ {6{POL}};
    seg_d     = (active_mask_q[slot_q] ? 7'b1000000 : decode(active_q[slot_q])) ^ {7{POL}};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q       <= '0;
      slot_q        <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      stage_q       <= '0;
      active_q      <= '0;
      stage_mask_q  <= '0;
      active_mask_q <= '0;
      pending_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      an_q          <= {6{POL}};
      seg_q         <= {7{POL}};
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        slot_q <= (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
      end
      frame_done_q <= boundary;

      if (load) begin
        stage_q      <= din;
        stage_mask_q <= mask;
      end
      // A load landing on the boundary bypasses staging so it is not a frame late.
      if (boundary && (load || pending_q)) begin
        active_q      <= load ? din : stage_q;
        active_mask_q <= load ? mask : stage_mask_q;
      end
      pending_q <= pending_d;

      if (!blink_en) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (boundary) begin
        if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end

      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = POL;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
